// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: sticky LSR/MSR event flags, THRE flag,
// RX character timeout and prioritised 16550-style ISR generation.
module uart_irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ier_i,
    input  logic       fifo_en_i,
    input  logic [1:0] rx_trig_i,
    input  logic [4:0] rx_count_i,
    input  logic       rx_push_i,
    input  logic       rx_pop_i,
    input  logic       tx_empty_i,
    input  logic       thr_wr_i,
    input  logic [3:0] lsr_err_i,
    input  logic [3:0] msr_delta_i,
    input  logic       lsr_rd_i,
    input  logic       msr_rd_i,
    input  logic       isr_rd_i,
    input  logic       baud_tick_i,
    input  logic [3:0] char_bits_i,
    output logic [7:0] isr_o,
    output logic       irq_o,
    output logic [3:0] lsr_err_o,
    output logic [3:0] msr_delta_o
);

    localparam logic [3:0] IID_LSR  = 4'b0110;
    localparam logic [3:0] IID_RX   = 4'b0100;
    localparam logic [3:0] IID_TMO  = 4'b1100;
    localparam logic [3:0] IID_THRE = 4'b0010;
    localparam logic [3:0] IID_MSR  = 4'b0000;
    localparam logic [3:0] IID_NONE = 4'b0001;

    logic [3:0] lsr_next;
    logic [3:0] msr_next;
    logic       thre;
    logic       thre_next;
    logic       thre_set;
    logic [5:0] tmo_cnt;
    logic [5:0] tmo_next;
    logic [5:0] tmo_lim;
    logic       tx_empty_q;
    logic       ier1_q;
    logic [4:0] trig_lvl;
    logic       rx_lvl;
    logic       tmo_hit;
    logic [3:0] iid;
    logic [7:0] isr_next;

    // Sticky flags: a same-cycle set survives the clearing read.
    always_comb begin
        lsr_next = lsr_rd_i ? lsr_err_i : (lsr_err_o | lsr_err_i);
        msr_next = msr_rd_i ? msr_delta_i : (msr_delta_o | msr_delta_i);
    end

    // THRE flag: set on TX-empty or enable rising edge, CPU write wins.
    always_comb begin
        thre_set  = (tx_empty_i & ~tx_empty_q)
                  | (ier_i[1] & ~ier1_q & tx_empty_i);
        thre_next = thre;
        if (isr_rd_i && isr_o[3:0] == IID_THRE)
            thre_next = 1'b0;
        if (thre_set)
            thre_next = 1'b1;
        if (thr_wr_i)
            thre_next = 1'b0;
    end

    // Character timeout counter, saturating at four character times.
    always_comb begin
        tmo_lim  = {char_bits_i, 2'b00};
        tmo_next = tmo_cnt;
        if (rx_push_i || rx_pop_i || rx_count_i == 5'd0)
            tmo_next = 6'd0;
        else if (baud_tick_i && tmo_cnt < tmo_lim)
            tmo_next = tmo_cnt + 6'd1;
    end

    // RX trigger threshold decode.
    always_comb begin
        trig_lvl = 5'd1;
        unique case (rx_trig_i)
            2'b00: trig_lvl = 5'd1;
            2'b01: trig_lvl = 5'd4;
            2'b10: trig_lvl = 5'd8;
            2'b11: trig_lvl = 5'd14;
        endcase
    end

    // Priority encode pending sources from next-state flags.
    always_comb begin
        rx_lvl  = ier_i[0] & (fifo_en_i ? (rx_count_i >= trig_lvl)
                                        : (rx_count_i != 5'd0));
        tmo_hit = fifo_en_i & ier_i[0] & (rx_count_i != 5'd0)
                & (tmo_next == tmo_lim);
        iid = IID_NONE;
        if (ier_i[2] && lsr_next != 4'd0)
            iid = IID_LSR;
        else if (tmo_hit)
            iid = IID_TMO;
        else if (rx_lvl)
            iid = IID_RX;
        else if (ier_i[1] && thre_next)
            iid = IID_THRE;
        else if (ier_i[3] && msr_next != 4'd0)
            iid = IID_MSR;
        isr_next = {{2{fifo_en_i}}, 2'b00, iid};
    end

    // State and registered interrupt outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isr_o       <= 8'h01;
            irq_o       <= 1'b0;
            lsr_err_o   <= 4'd0;
            msr_delta_o <= 4'd0;
            thre        <= 1'b0;
            tmo_cnt     <= 6'd0;
            tx_empty_q  <= 1'b0;
            ier1_q      <= 1'b0;
        end else begin
            isr_o       <= isr_next;
            irq_o       <= ~isr_next[0];
            lsr_err_o   <= lsr_next;
            msr_delta_o <= msr_next;
            thre        <= thre_next;
            tmo_cnt     <= tmo_next;
            tx_empty_q  <= tx_empty_i;
            ier1_q      <= ier_i[1];
        end
    end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Scoreboard bench for uart_irq_ctrl: driver queues expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_uart_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ier_i;
    logic       fifo_en_i;
    logic [1:0] rx_trig_i;
    logic [4:0] rx_count_i;
    logic       rx_push_i;
    logic       rx_pop_i;
    logic       tx_empty_i;
    logic       thr_wr_i;
    logic [3:0] lsr_err_i;
    logic [3:0] msr_delta_i;
    logic       lsr_rd_i;
    logic       msr_rd_i;
    logic       isr_rd_i;
    logic       baud_tick_i;
    logic [3:0] char_bits_i;
    logic [7:0] isr_o;
    logic       irq_o;
    logic [3:0] lsr_err_o;
    logic [3:0] msr_delta_o;

    typedef struct {
        string      name;
        logic [7:0] isr;
        logic       irq;
        logic [3:0] lsr;
        logic [3:0] msr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_irq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ier_i       (ier_i),
        .fifo_en_i   (fifo_en_i),
        .rx_trig_i   (rx_trig_i),
        .rx_count_i  (rx_count_i),
        .rx_push_i   (rx_push_i),
        .rx_pop_i    (rx_pop_i),
        .tx_empty_i  (tx_empty_i),
        .thr_wr_i    (thr_wr_i),
        .lsr_err_i   (lsr_err_i),
        .msr_delta_i (msr_delta_i),
        .lsr_rd_i    (lsr_rd_i),
        .msr_rd_i    (msr_rd_i),
        .isr_rd_i    (isr_rd_i),
        .baud_tick_i (baud_tick_i),
        .char_bits_i (char_bits_i),
        .isr_o       (isr_o),
        .irq_o       (irq_o),
        .lsr_err_o   (lsr_err_o),
        .msr_delta_o (msr_delta_o)
    );

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        while (q.size() != 0) begin
            e = q.pop_front();
            n_cmp++;
            if (isr_o !== e.isr || irq_o !== e.irq ||
                lsr_err_o !== e.lsr || msr_delta_o !== e.msr) begin
                n_err++;
                $display("FAIL %s: got isr=%h irq=%b lsr=%b msr=%b, want isr=%h irq=%b lsr=%b msr=%b",
                         e.name, isr_o, irq_o, lsr_err_o, msr_delta_o,
                         e.isr, e.irq, e.lsr, e.msr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] isr,
                              input logic [3:0] lsr, input logic [3:0] msr);
        exp_t x;
        x.name = nm;
        x.isr  = isr;
        x.irq  = ~isr[0];
        x.lsr  = lsr;
        x.msr  = msr;
        q.push_back(x);
    endtask

    initial begin
        rst = 1'b0;
        ier_i = 4'd0; fifo_en_i = 1'b0; rx_trig_i = 2'd0;
        rx_count_i = 5'd0; rx_push_i = 1'b0; rx_pop_i = 1'b0;
        tx_empty_i = 1'b0; thr_wr_i = 1'b0; lsr_err_i = 4'd0;
        msr_delta_i = 4'd0; lsr_rd_i = 1'b0; msr_rd_i = 1'b0;
        isr_rd_i = 1'b0; baud_tick_i = 1'b0; char_bits_i = 4'd10;

        step(); step();
        expect_out("in_reset", 8'h01, 4'd0, 4'd0);
        step();
        rst = 1'b1;
        step();
        expect_out("reset_release", 8'h01, 4'd0, 4'd0);

        // THR empty
        fifo_en_i = 1'b1; ier_i = 4'b0010;
        step(); expect_out("thre_idle", 8'hC1, 4'd0, 4'd0);
        tx_empty_i = 1'b1;
        step(); expect_out("thre_set", 8'hC2, 4'd0, 4'd0);
        isr_rd_i = 1'b1;
        step(); isr_rd_i = 1'b0;
        expect_out("thre_isr_rd", 8'hC1, 4'd0, 4'd0);
        ier_i = 4'b0000;
        step(); expect_out("thre_ier_off", 8'hC1, 4'd0, 4'd0);
        ier_i = 4'b0010;
        step(); expect_out("thre_ier_edge", 8'hC2, 4'd0, 4'd0);
        thr_wr_i = 1'b1;
        step(); thr_wr_i = 1'b0;
        expect_out("thre_thr_wr", 8'hC1, 4'd0, 4'd0);
        tx_empty_i = 1'b0; ier_i = 4'b0000;
        step(); expect_out("thre_done", 8'hC1, 4'd0, 4'd0);

        // Priority: line status over RX data
        ier_i = 4'b1111; rx_trig_i = 2'b10; rx_count_i = 5'd8;
        lsr_err_i = 4'b0001;
        step(); lsr_err_i = 4'd0;
        expect_out("prio_lsr", 8'hC6, 4'b0001, 4'd0);
        lsr_rd_i = 1'b1;
        step(); lsr_rd_i = 1'b0;
        expect_out("prio_rx", 8'hC4, 4'd0, 4'd0);
        rx_count_i = 5'd7;
        step(); expect_out("prio_below_trig", 8'hC1, 4'd0, 4'd0);

        // Character timeout
        ier_i = 4'b0001; rx_trig_i = 2'b11; rx_count_i = 5'd3;
        step(); expect_out("tmo_start", 8'hC1, 4'd0, 4'd0);
        baud_tick_i = 1'b1;
        repeat (39) step();
        expect_out("tmo_39_ticks", 8'hC1, 4'd0, 4'd0);
        step(); baud_tick_i = 1'b0;
        expect_out("tmo_40_ticks", 8'hCC, 4'd0, 4'd0);
        step(); expect_out("tmo_hold", 8'hCC, 4'd0, 4'd0);
        rx_pop_i = 1'b1;
        step(); rx_pop_i = 1'b0;
        expect_out("tmo_pop", 8'hC1, 4'd0, 4'd0);
        baud_tick_i = 1'b1;
        repeat (43) step();
        baud_tick_i = 1'b0;
        expect_out("tmo_saturate", 8'hCC, 4'd0, 4'd0);
        rx_count_i = 5'd0;
        step(); expect_out("tmo_empty", 8'hC1, 4'd0, 4'd0);

        // RX level, non-FIFO and FIFO trigger boundary
        fifo_en_i = 1'b0; rx_count_i = 5'd1;
        step(); expect_out("rx_nofifo", 8'h04, 4'd0, 4'd0);
        rx_count_i = 5'd0;
        step(); expect_out("rx_nofifo_empty", 8'h01, 4'd0, 4'd0);
        fifo_en_i = 1'b1; rx_trig_i = 2'b01; rx_count_i = 5'd4;
        step(); expect_out("rx_trig4", 8'hC4, 4'd0, 4'd0);
        rx_count_i = 5'd3;
        step(); expect_out("rx_trig4_below", 8'hC1, 4'd0, 4'd0);
        rx_count_i = 5'd0;

        // Modem status
        ier_i = 4'b1000; msr_delta_i = 4'b0100;
        step(); msr_delta_i = 4'd0;
        expect_out("msr_set", 8'hC0, 4'd0, 4'b0100);
        msr_rd_i = 1'b1;
        step(); msr_rd_i = 1'b0;
        expect_out("msr_rd", 8'hC1, 4'd0, 4'd0);
        msr_delta_i = 4'b0001; msr_rd_i = 1'b1;
        step(); msr_delta_i = 4'd0; msr_rd_i = 1'b0;
        expect_out("msr_collide", 8'hC0, 4'd0, 4'b0001);
        msr_rd_i = 1'b1;
        step(); msr_rd_i = 1'b0;
        expect_out("msr_clear", 8'hC1, 4'd0, 4'd0);

        // LSR set/read collision and re-enable exposure
        ier_i = 4'b0100; lsr_err_i = 4'b0010; lsr_rd_i = 1'b1;
        step(); lsr_err_i = 4'd0; lsr_rd_i = 1'b0;
        expect_out("lsr_collide", 8'hC6, 4'b0010, 4'd0);
        ier_i = 4'b0000;
        step(); expect_out("lsr_masked", 8'hC1, 4'b0010, 4'd0);
        ier_i = 4'b0100;
        step(); expect_out("lsr_reenable", 8'hC6, 4'b0010, 4'd0);
        lsr_rd_i = 1'b1;
        step(); lsr_rd_i = 1'b0;
        expect_out("lsr_rd", 8'hC1, 4'd0, 4'd0);

        // Reset mid-operation discards pending events
        ier_i = 4'b1000; msr_delta_i = 4'b1000;
        step(); msr_delta_i = 4'd0;
        expect_out("pre_reset", 8'hC0, 4'd0, 4'b1000);
        step();
        rst = 1'b0;
        #1;
        expect_out("mid_reset", 8'h01, 4'd0, 4'd0);
        step();
        rst = 1'b1;
        step(); expect_out("post_reset", 8'hC1, 4'd0, 4'd0);

        repeat (3) step();
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_irq_ctrl.md
UART_IRQ_CTRL -- requirements
Module: uart_irq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port ier_i, input, 4: interrupt enables.
- bit0 RX data available.
- bit1 THR empty.
- bit2 line status.
- bit3 modem status.
REQ-004 SHALL have port fifo_en_i, input, 1: FIFO mode enabled (FCR[0]).
REQ-005 SHALL have port rx_trig_i, input, 2: RX trigger level; 00=1, 01=4, 10=8, 11=14 bytes.
REQ-006 SHALL have port rx_count_i, input, 5: RX FIFO occupancy, 0..16.
REQ-007 SHALL have ports rx_push_i and rx_pop_i, input, 1 each: single-cycle receiver push and CPU RHR pop pulses.
REQ-008 SHALL have port tx_empty_i, input, 1: TX FIFO/THR empty level.
REQ-009 SHALL have port thr_wr_i, input, 1: CPU THR write pulse.
REQ-010 SHALL have port lsr_err_i, input, 4: error event pulses {BI,FE,PE,OE}.
REQ-011 SHALL have port msr_delta_i, input, 4: modem delta event pulses.
REQ-012 SHALL have ports lsr_rd_i, msr_rd_i, isr_rd_i, input, 1 each: CPU read strobes of LSR, MSR, ISR.
REQ-013 SHALL have port baud_tick_i, input, 1: one pulse per bit time.
REQ-014 SHALL have port char_bits_i, input, 4: bit times per character, 7..12.
REQ-015 SHALL have port isr_o, output, 8: ISR value.
REQ-016 SHALL have port irq_o, output, 1: interrupt to CPU.
REQ-017 SHALL have port lsr_err_o, output, 4: sticky error bits for LSR.
REQ-018 SHALL have port msr_delta_o, output, 4: sticky modem delta bits.

Function
REQ-019 SHALL register isr_o and irq_o; both reflect events exactly one clk after the causing input.
REQ-020 SHALL assert irq_o as ~isr_o[0].
REQ-021 SHALL set isr_o[7:6]=11 when fifo_en_i=1, else 00; isr_o[5:4]=00.
REQ-022 SHALL set isr_o[3:0] to the highest pending source; none pending gives 0001.
- 0110 line status (priority 1).
- 0100 RX data available (2).
- 1100 character timeout (2).
- 0010 THR empty (3).
- 0000 modem (4).
REQ-023 SHALL set lsr_err_o bits from lsr_err_i pulses and clear all on lsr_rd_i; set and read in the same cycle leaves the new bits set.
REQ-024 SHALL raise line status pending when ier_i[2]=1 and lsr_err_o is nonzero.
REQ-025 SHALL raise RX data available when ier_i[0]=1 and rx_count_i meets the level condition.
- FIFO mode: rx_count_i >= trigger level.
- Non-FIFO mode: rx_count_i != 0.
- Level-based, no latch.
REQ-026 SHALL keep a 6-bit timeout counter with this behaviour.
- Clears on rx_push_i, rx_pop_i, or rx_count_i==0.
- Otherwise increments on baud_tick_i.
- Saturates at 4*char_bits_i.
REQ-027 SHALL raise timeout when fifo_en_i=1, ier_i[0]=1, rx_count_i!=0 and the counter equals 4*char_bits_i.
REQ-028 SHALL rank timeout above RX data available when both are pending.
REQ-029 SHALL set the THRE flag on a tx_empty_i 0->1 transition, or on an ier_i[1] 0->1 transition while tx_empty_i=1.
REQ-030 SHALL clear the THRE flag on thr_wr_i, or on isr_rd_i while isr_o[3:0]=0010; thr_wr_i wins over a simultaneous set.
REQ-031 SHALL raise THR empty pending when ier_i[1]=1 and the THRE flag is set.
REQ-032 SHALL set msr_delta_o bits from msr_delta_i pulses and clear them on msr_rd_i, with set priority over a same-cycle read.
REQ-033 SHALL raise modem pending when ier_i[3]=1 and msr_delta_o is nonzero.
REQ-034 SHALL keep disabled sources' sticky flags intact, so re-enabling exposes them on the next cycle.

Reset
REQ-035 SHALL, while rst=0, drive the following reset values:
- isr_o=8'h01, irq_o=0.
- lsr_err_o=0, msr_delta_o=0.
- THRE flag=0, timeout counter=0, edge-detect registers=0.
REQ-036 SHALL discard any pending event when rst asserts mid-operation, with no interrupt one cycle after release.

Verification
REQ-037 SHALL pass reset: rst released, all inputs 0 -> isr_o=0x01, irq_o=0.
REQ-038 SHALL pass THRE: fifo_en=1, ier=0010, tx_empty 0->1 -> next cycle isr_o=0xC2, irq_o=1; isr_rd_i pulse -> isr_o=0xC1.
REQ-039 SHALL pass priority: ier=1111, trig=10, rx_count=8, lsr_err_i=0001 pulse.
- isr_o=0xC6.
- lsr_rd_i -> 0xC4.
- rx_count to 7 -> 0xC1.
REQ-040 SHALL pass timeout: fifo_en=1, ier=0001, trig=11, rx_count=3, char_bits=10, 40 ticks with no push/pop.
- isr_o=0xCC one cycle after the 40th tick.
- rx_pop_i -> 0xC1.
REQ-041 SHALL pass modem: ier=1000, msr_delta_i=0100 -> isr_o=0xC0, msr_delta_o=0100; msr_rd_i -> 0xC1.
REQ-042 SHALL pass collision: lsr_err_i=0010 and lsr_rd_i in the same cycle -> lsr_err_o=0010, isr_o=0xC6 (ier[2]=1).
